// File: rtl/clk_rate_gen.sv
// Programmable phase-accumulator test clock with a per-frame rising-edge counter.
// Optional self-check of the edge count is enabled by defining CLK_RATE_GEN_SELFCHECK_EN.
module clk_rate_gen #(
    parameter logic [23:0] WINDOW    = 24'd1000000,
    parameter logic [23:0] FRAME_END = 24'h800000,
    parameter logic [23:0] SNAP_AT   = 24'h100000,
    parameter logic [23:0] CLEAR_AT  = 24'h110000
) (
    input  logic        clk100,
    input  logic        reset_in,
    input  logic        enable,
    input  logic [31:0] cfg_incr,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    output logic        clk_out,
    output logic [31:0] edge_count,
    output logic        count_valid,
    output logic        running
`ifdef CLK_RATE_GEN_SELFCHECK_EN
    ,
    output logic        check_fail
`endif
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    localparam logic [31:0] EdgeSat = 32'hFFFF_FFFE;
    localparam logic [31:0] NoData  = 32'hFFFF_FFFF;

    state_e      state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] incr_q, incr_d;
    logic [31:0] pend_incr_q, pend_incr_d;
    logic        pend_q, pend_d;
    logic        clk_out_q, clk_out_d;
    logic [23:0] frame_q, frame_d;
    logic [31:0] edge_cnt_q, edge_cnt_d;
    logic [31:0] edge_count_q, edge_count_d;
    logic        count_valid_q, count_valid_d;

    logic [32:0] sum_ext;
    logic [31:0] sum;
    logic        carry;
    logic        cfg_xfer;

    always_comb begin
        sum_ext = {1'b0, acc_q} + {1'b0, incr_q};
        sum     = sum_ext[31:0];
        carry   = sum_ext[32];
        cfg_xfer = cfg_valid && !pend_q;

        state_d   = state_q;
        acc_d     = acc_q;
        clk_out_d = clk_out_q;
        unique case (state_q)
            StIdle: begin
                acc_d     = 32'd0;
                clk_out_d = 1'b0;
                if (enable) state_d = StRun;
            end
            StRun, StDrain: begin
                acc_d     = sum;
                clk_out_d = sum[31];
                // Stop only once the output would be low, so the last high phase is whole.
                if (!enable && !sum[31]) begin
                    state_d   = StIdle;
                    acc_d     = 32'd0;
                    clk_out_d = 1'b0;
                end else if (!enable) begin
                    state_d = StDrain;
                end else begin
                    state_d = StRun;
                end
            end
            default: begin
                state_d   = StIdle;
                acc_d     = 32'd0;
                clk_out_d = 1'b0;
            end
        endcase
    end

    // Increment changes only at a wrap while running, so periods are never cut short.
    always_comb begin
        incr_d      = incr_q;
        pend_d      = pend_q;
        pend_incr_d = pend_incr_q;
        if (state_q == StIdle) begin
            if (pend_q) begin
                incr_d = pend_incr_q;
                pend_d = 1'b0;
            end else if (cfg_valid) begin
                incr_d = cfg_incr;
            end
        end else begin
            if (pend_q && carry) begin
                incr_d = pend_incr_q;
                pend_d = 1'b0;
            end else if (cfg_xfer) begin
                pend_d      = 1'b1;
                pend_incr_d = cfg_incr;
            end
        end
    end

    always_comb begin
        frame_d = (frame_q == FRAME_END) ? 24'd0 : frame_q + 24'd1;

        edge_cnt_d = edge_cnt_q;
        if (frame_q == CLEAR_AT) begin
            edge_cnt_d = 32'd0;
        end else if (clk_out_d && !clk_out_q && (frame_q < WINDOW) && (edge_cnt_q != EdgeSat)) begin
            edge_cnt_d = edge_cnt_q + 32'd1;
        end

        edge_count_d  = edge_count_q;
        count_valid_d = 1'b0;
        if (frame_q == SNAP_AT) begin
            edge_count_d  = edge_cnt_q;
            count_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk100) begin
        if (reset_in) begin
            state_q       <= StIdle;
            acc_q         <= 32'd0;
            incr_q        <= 32'd0;
            pend_q        <= 1'b0;
            pend_incr_q   <= 32'd0;
            clk_out_q     <= 1'b0;
            frame_q       <= 24'd0;
            edge_cnt_q    <= 32'd0;
            edge_count_q  <= NoData;
            count_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            incr_q        <= incr_d;
            pend_q        <= pend_d;
            pend_incr_q   <= pend_incr_d;
            clk_out_q     <= clk_out_d;
            frame_q       <= frame_d;
            edge_cnt_q    <= edge_cnt_d;
            edge_count_q  <= edge_count_d;
            count_valid_q <= count_valid_d;
        end
    end

    assign cfg_ready   = !pend_q;
    assign clk_out     = clk_out_q;
    assign edge_count  = edge_count_q;
    assign count_valid = count_valid_q;
    assign running     = (state_q == StRun) || (state_q == StDrain);

`ifdef CLK_RATE_GEN_SELFCHECK_EN
    logic        dirty_q, dirty_d;
    logic        check_fail_q, check_fail_d;
    logic        disturbed;
    logic [31:0] pred;
    logic [31:0] diff;

    // A window is trusted only if the FSM stayed in RUN with one increment since the clear.
    always_comb begin
        pred      = 32'((56'(incr_q) * 56'(WINDOW)) >> 32);
        diff      = (edge_cnt_q >= pred) ? edge_cnt_q - pred : pred - edge_cnt_q;
        disturbed = (state_q != StRun) || (incr_d != incr_q);
        dirty_d   = (frame_q == CLEAR_AT) ? disturbed : (dirty_q | disturbed);
        check_fail_d = check_fail_q;
        if ((frame_q == SNAP_AT) && !dirty_q && (diff > 32'd1)) check_fail_d = 1'b1;
    end

    always_ff @(posedge clk100) begin
        if (reset_in) begin
            dirty_q      <= 1'b1;
            check_fail_q <= 1'b0;
        end else begin
            dirty_q      <= dirty_d;
            check_fail_q <= check_fail_d;
        end
    end

    assign check_fail = check_fail_q;
`endif

endmodule

// File: tb/tb_clk_rate_gen.sv
// Directed bench for clk_rate_gen using a shortened frame so whole windows fit in a short run.
module tb_clk_rate_gen;

    localparam logic [23:0] TbWindow   = 24'd1000;
    localparam logic [23:0] TbFrameEnd = 24'd2047;
    localparam logic [23:0] TbSnapAt   = 24'd1024;
    localparam logic [23:0] TbClearAt  = 24'd1088;

    logic        clk100;
    logic        reset_in;
    logic        enable;
    logic [31:0] cfg_incr;
    logic        cfg_valid;
    logic        cfg_ready;
    logic        clk_out;
    logic [31:0] edge_count;
    logic        count_valid;
    logic        running;
`ifdef CLK_RATE_GEN_SELFCHECK_EN
    logic        check_fail;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    clk_rate_gen #(
        .WINDOW   (TbWindow),
        .FRAME_END(TbFrameEnd),
        .SNAP_AT  (TbSnapAt),
        .CLEAR_AT (TbClearAt)
    ) dut (
        .clk100     (clk100),
        .reset_in   (reset_in),
        .enable     (enable),
        .cfg_incr   (cfg_incr),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .clk_out    (clk_out),
        .edge_count (edge_count),
        .count_valid(count_valid),
        .running    (running)
`ifdef CLK_RATE_GEN_SELFCHECK_EN
        ,
        .check_fail (check_fail)
`endif
    );

    initial clk100 = 1'b0;
    always #5 clk100 = ~clk100;

    initial begin
        #(90000 * 10);
        $display("FAIL watchdog: got no finish, want finish within 90000 cycles");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h (%0d), want 0x%0h (%0d)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic wait_pulse(input string tag);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 4200 && !got; i++) begin
            @(negedge clk100);
            if (count_valid) got = 1'b1;
        end
        check_eq({tag, "_seen"}, {31'd0, got}, 32'd1);
    endtask

    task automatic offer_cfg(input logic [31:0] val);
        @(negedge clk100);
        cfg_incr  = val;
        cfg_valid = 1'b1;
        @(negedge clk100);
        cfg_valid = 1'b0;
    endtask

    initial begin
        int          n_pulse;
        int          hi_bad;
        int          bad;
        int          hi_len;
        int          run_len;
        int          min_phase;
        int          rdy_low;
        logic        prev;
        logic        seen_edge;
        logic [31:0] pulse_val;

        reset_in  = 1'b1;
        enable    = 1'b0;
        cfg_incr  = 32'd0;
        cfg_valid = 1'b0;
        repeat (3) @(negedge clk100);
        check_eq("rst_clk_out", {31'd0, clk_out}, 32'd0);
        check_eq("rst_edge_count", edge_count, 32'hFFFF_FFFF);
        check_eq("rst_count_valid", {31'd0, count_valid}, 32'd0);
        check_eq("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
        check_eq("rst_running", {31'd0, running}, 32'd0);
        reset_in = 1'b0;

        // Idle for 1.2 frames: exactly one report, carrying zero edges.
        n_pulse   = 0;
        hi_bad    = 0;
        pulse_val = 32'hDEAD_BEEF;
        for (int i = 0; i < 2458; i++) begin
            @(negedge clk100);
            if (clk_out) hi_bad++;
            if (count_valid) begin
                n_pulse++;
                pulse_val = edge_count;
            end
        end
        check_eq("idle_clk_out_high_cycles", hi_bad, 0);
        check_eq("idle_pulse_count", n_pulse, 1);
        check_eq("idle_pulse_edge_count", pulse_val, 32'd0);

        // Maximum rate, loaded while idle.
        offer_cfg(32'h8000_0000);
        enable = 1'b1;
        repeat (3) @(negedge clk100);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            prev = clk_out;
            @(negedge clk100);
            if (clk_out == prev) bad++;
        end
        check_eq("max_toggle_misses", bad, 0);
        check_eq("max_running", {31'd0, running}, 32'd1);
        wait_pulse("max_skip");
        wait_pulse("max_win");
        check_eq("max_edge_count", edge_count, 32'd500);

        // 4 MHz, loaded while running (applies on the next wrap).
        offer_cfg(32'h0A3D_70A4);
        repeat (4) @(negedge clk100);
        check_eq("m4_cfg_ready_back", {31'd0, cfg_ready}, 32'd1);
        wait_pulse("m4_skip");
        wait_pulse("m4_win");
        check_eq($sformatf("m4_count_in_39_41(got %0d)", edge_count),
                 {31'd0, (edge_count >= 32'd39) && (edge_count <= 32'd41)}, 32'd1);
`ifdef CLK_RATE_GEN_SELFCHECK_EN
        check_eq("m4_check_fail", {31'd0, check_fail}, 32'd0);
`endif

        // Switch to 2 MHz during RUN; watch handshake latency and phase lengths.
        offer_cfg(32'h051E_B852);
        check_eq("cfg_run_ready_low", {31'd0, cfg_ready}, 32'd0);
        rdy_low   = 1;
        min_phase = 1000;
        run_len   = 0;
        seen_edge = 1'b0;
        prev      = clk_out;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk100);
            if (!cfg_ready) rdy_low++;
            if (clk_out != prev) begin
                if (seen_edge && run_len < min_phase) min_phase = run_len;
                seen_edge = 1'b1;
                run_len   = 1;
            end else begin
                run_len++;
            end
            prev = clk_out;
        end
        check_eq($sformatf("cfg_run_ready_low_cycles_1_26(got %0d)", rdy_low),
                 {31'd0, (rdy_low >= 1) && (rdy_low <= 26)}, 32'd1);
        check_eq($sformatf("cfg_run_min_phase_ge_12(got %0d)", min_phase),
                 {31'd0, min_phase >= 12}, 32'd1);
        wait_pulse("m2_skip");
        wait_pulse("m2_win");
        check_eq($sformatf("m2_count_in_19_21(got %0d)", edge_count),
                 {31'd0, (edge_count >= 32'd19) && (edge_count <= 32'd21)}, 32'd1);
`ifdef CLK_RATE_GEN_SELFCHECK_EN
        check_eq("m2_check_fail", {31'd0, check_fail}, 32'd0);
`endif

        // Drain: drop enable during a high phase.
        for (int i = 0; i < 100 && !clk_out; i++) @(negedge clk100);
        enable = 1'b0;
        bad    = 0;
        for (int i = 0; i < 100 && clk_out; i++) begin
            @(negedge clk100);
            if (clk_out && !running) bad++;
        end
        check_eq("drain_clk_out_low", {31'd0, clk_out}, 32'd0);
        check_eq("drain_running_low", {31'd0, running}, 32'd0);
        check_eq("drain_running_dropped_early", bad, 0);
        repeat (10) @(negedge clk100);
        check_eq("drain_idle_clk_out", {31'd0, clk_out}, 32'd0);

        // Resume from DRAIN: the interrupted high phase keeps its full length.
        enable = 1'b1;
        for (int i = 0; i < 100 && !clk_out; i++) @(negedge clk100);
        hi_len = 1;
        bad    = 0;
        for (int i = 0; i < 100 && clk_out; i++) begin
            if (i == 2) enable = 1'b0;
            if (i == 4) enable = 1'b1;
            @(negedge clk100);
            if (clk_out) hi_len++;
            if (!running) bad++;
        end
        check_eq($sformatf("resume_high_phase_24_26(got %0d)", hi_len),
                 {31'd0, (hi_len >= 24) && (hi_len <= 26)}, 32'd1);
        check_eq("resume_running_gaps", bad, 0);

        // Reset mid-window with a pending config.
        wait_pulse("mid_sync");
        repeat (1500) @(negedge clk100);
        offer_cfg(32'h0A3D_70A4);
        check_eq("mid_pend_ready_low", {31'd0, cfg_ready}, 32'd0);
        reset_in = 1'b1;
        @(negedge clk100);
        reset_in = 1'b0;
        check_eq("mid_rst_clk_out", {31'd0, clk_out}, 32'd0);
        check_eq("mid_rst_edge_count", edge_count, 32'hFFFF_FFFF);
        check_eq("mid_rst_count_valid", {31'd0, count_valid}, 32'd0);
        check_eq("mid_rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
        check_eq("mid_rst_running", {31'd0, running}, 32'd0);

        // Pending value was dropped: increment is 0, so the output never moves.
        hi_bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk100);
            if (clk_out) hi_bad++;
        end
        check_eq("zero_incr_high_cycles", hi_bad, 0);
        check_eq("zero_incr_running", {31'd0, running}, 32'd1);
        wait_pulse("zero_win");
        check_eq("zero_incr_edge_count", edge_count, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/clk_rate_gen.md
# clk_rate_gen

Programmable test-clock generator in the `clk100` domain. It is the stimulus end of the clock-rate measurement path. A 32-bit phase accumulator produces a square-wave `clk_out` at `f = cfg_incr × 100 MHz / 2^32`. The block also counts its own rising edges over the same 10 ms frame the rate measurer uses, so a loopback reading can be compared directly against `edge_count`. It sits in the tile-test support fabric and drives a loopback pin or cable-test lane.

## Interface

**Parameters**

- `WINDOW`, default 24'd1000000: counting window length in `clk100` cycles.
- `FRAME_END`, default 24'h800000: last value of the frame counter before it wraps.

**Ports**

- `clk100` in 1: 100 MHz system clock; the only clock.
- `reset_in` in 1: synchronous, active-high reset.
- `enable` in 1: level; run the generator when high.
- `cfg_incr` in 32: phase increment.
- `cfg_valid` in 1: `cfg_incr` is offered.
- `cfg_ready` out 1: a new increment can be accepted.
- `clk_out` out 1: generated test clock, registered.
- `edge_count` out 32: rising edges of `clk_out` seen in the last window.
- `count_valid` out 1: one-cycle pulse when `edge_count` updates.
- `running` out 1: FSM is in RUN or DRAIN.

## Operation

- **Reset values:** `clk_out`=0, `edge_count`=32'hFFFFFFFF (the "no data" marker), `count_valid`=0, `cfg_ready`=1, `running`=0. Internally: accumulator=0, active increment=0, pending flag=0, frame counter=0, FSM=IDLE.
- **Config handshake:** a transfer occurs when `cfg_valid` && `cfg_ready`.
  - In IDLE the value loads directly into the active increment.
  - In RUN the value goes into a pending register, pending is set, and `cfg_ready` drops.
  - The pending value is applied on the cycle the accumulator carries out (wraps). Pending then clears and `cfg_ready` rises on the next cycle.
  - This keeps every period whole: no runt pulses.
- **FSM states:**
  - IDLE: accumulator held at 0, `clk_out`=0. Go to RUN when `enable`=1.
  - RUN: `acc <= acc + incr` every cycle, and `clk_out <= acc[31]` (the value after the add). Go to DRAIN when `enable`=0.
  - DRAIN: keep accumulating until `acc[31]` is 0. If `acc[31]` is already 0 on entry, go to IDLE immediately. On reaching IDLE, clear the accumulator; `clk_out` ends low. If `enable` returns high during DRAIN, go back to RUN without clearing.
- **Increment boundaries:**
  - `cfg_incr`=0: `clk_out` stays constant.
  - `cfg_incr`=32'h80000000: `clk_out` toggles every cycle, i.e. 50 MHz, the maximum.
  - Increments above 32'h80000000 alias (output frequency folds back); this is not an error.
- **Frame counter:** 24-bit, counts 0..`FRAME_END` and then wraps to 0, giving a frame of 8,388,609 cycles.
  - A rising edge of `clk_out` is counted only while the frame counter is below `WINDOW`. The edge counter is 32-bit and saturates at 32'hFFFFFFFE.
  - At frame counter = 24'h100000: `edge_count` <= edge counter and `count_valid`=1 for that one cycle.
  - At frame counter = 24'h110000: the edge counter clears to 0.
- **Reset mid-operation:** every register returns to its reset value on the next edge. Any pending config is discarded.

## Timing

- `clk_out` is registered: the first rising edge appears no earlier than 2 cycles after `enable` is first sampled high.
- Handshake latency:
  - IDLE: 0 cycles to take effect.
  - RUN: takes effect at the next accumulator wrap, at most ceil(2^32/old_incr) cycles later; `cfg_ready` recovers 1 cycle after that wrap.
- `count_valid` asserts exactly once per frame: 1,048,576 cycles after each frame-counter wrap.
- Expected count: `edge_count` ≈ `cfg_incr` × `WINDOW` / 2^32, within ±1. Both `enable` and `cfg_incr` must have been stable for the whole window.

## Configuration

- Macro `CLK_RATE_GEN_SELFCHECK_EN`.
- **Defined:**
  - Adds output `check_fail` (1 bit, reset 0).
  - On each `count_valid`, compute predicted = (active_incr × `WINDOW`) >> 32 using a 56-bit product.
  - Set `check_fail` if |`edge_count` − predicted| > 1. The flag is sticky until `reset_in`.
  - The check is skipped for any window during which the increment changed or the FSM left RUN.
- **Undefined:** the port and the logic are absent.

## Test plan

- **Reset:** apply reset, then hold `enable`=0 for 1.2 M cycles → `clk_out`=0, `edge_count`=32'hFFFFFFFF, exactly one `count_valid` pulse carrying `edge_count`=0.
- **Maximum rate:** set `cfg_incr`=32'h80000000, `enable`=1, wait a full frame → `clk_out` toggles every cycle and `edge_count`=500000.
- **4 MHz:** set `cfg_incr`=32'h0A3D70A4 → `edge_count` ∈ {39999, 40000, 40001}. With the macro defined, `check_fail` stays 0.
- **Config during RUN:** at 4 MHz, offer 32'h051EB852 → `cfg_ready` stays low until the next carry, and no high or low phase is shorter than the old half-period minus 1 cycle. The following window reads 20000±1.
- **Drain:** drop `enable` while `clk_out`=1 → `running` stays high until `clk_out` falls, then goes low. Raising `enable` during DRAIN resumes RUN without a glitch.
- **Reset mid-run:** assert `reset_in` for 1 cycle in the middle of a window → all outputs return to their reset values on the next edge, and the pending config is dropped (`cfg_ready`=1).
